// File: rtl/vector_config_unit_pkg.sv
// Shared types and constants for the vector configuration unit.
//   vew_e      : vsew encodings (element width)
//   vlmul_e    : vlmul encodings (integral, reserved, fractional)
//   vcfg_op_e  : configuration instruction selector
//   csr_op_e   : Zicsr access kind
//   CSR_*      : vector CSR addresses
package vector_config_unit_pkg;

    typedef enum logic [2:0] {
        EW8  = 3'b000,
        EW16 = 3'b001,
        EW32 = 3'b010,
        EW64 = 3'b011
    } vew_e;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [1:0] {
        VSETVLI  = 2'd0,
        VSETIVLI = 2'd1,
        VSETVL   = 2'd2
    } vcfg_op_e;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_VSTART = 12'h008;
    localparam logic [11:0] CSR_VXSAT  = 12'h009;
    localparam logic [11:0] CSR_VXRM   = 12'h00A;
    localparam logic [11:0] CSR_VCSR   = 12'h00F;
    localparam logic [11:0] CSR_VL     = 12'hC20;
    localparam logic [11:0] CSR_VTYPE  = 12'hC21;
    localparam logic [11:0] CSR_VLENB  = 12'hC22;

    // Architectural vtype value reported for an illegal configuration.
    localparam logic [31:0] VTYPE_VILL = 32'h8000_0000;

endpackage

// File: rtl/vector_config_unit_vtype_decode.sv
// Combinational vtype legality check and VLMAX computation.
//   vtype     in  : candidate vtype value
//   illegal   out : vtype not supported for this VLEN/ELEN
//   vlmax     out : VLMAX for vtype (0 when illegal)
//   vtype_eff out : vtype as it would be committed (VTYPE_VILL when illegal)
module vector_config_unit_vtype_decode
    import vector_config_unit_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 32
) (
    input  logic [31:0]            vtype,
    output logic                   illegal,
    output logic [$clog2(VLEN):0]  vlmax,
    output logic [31:0]            vtype_eff
);

    localparam int unsigned VW = $clog2(VLEN) + 1;

    logic [2:0]    vsew;
    vlmul_e        vlmul;
    logic [3:0]    frac_sh;
    int unsigned   sew_bits;
    int unsigned   frac_elen;
    logic [VW-1:0] base;
    logic [VW-1:0] vlmax_raw;

    always_comb begin
        vsew      = vtype[5:3];
        vlmul     = vlmul_e'(vtype[2:0]);
        frac_sh   = 4'd8 - {1'b0, vtype[2:0]};
        sew_bits  = 32'd8 << vsew;
        frac_elen = ELEN >> frac_sh;
        // Elements per single register; integral LMUL scales up, fractional down.
        base      = VW'(VLEN >> (3 + 32'(vsew)));
        vlmax_raw = vtype[2] ? (base >> frac_sh) : (base << vtype[1:0]);

        illegal = vtype[31]
               || (vtype[30:8] != '0)
               || (vsew > 3'd3)
               || (sew_bits > ELEN)
               || (vlmul == LMUL_RSVD)
               || (vtype[2] && (vlmul != LMUL_RSVD) && (sew_bits > frac_elen));

        vlmax     = illegal ? '0 : vlmax_raw;
        vtype_eff = illegal ? VTYPE_VILL : vtype;
    end

endmodule

// File: rtl/vector_config_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl through a
// valid/ready handshake (waiting for the vector pipeline to drain before
// committing) and owns the vector CSR file.
//   clk, reset              : clock, async active-high reset
//   cfg_valid_i/cfg_ready_o : request handshake; cfg_* operands latched on accept
//   cfg_done_o, cfg_vl_o    : one-cycle commit pulse with the new vl for rd
//   vec_busy_i              : vector instructions in flight (holds the commit)
//   csr_*                   : Zicsr access, combinational read data / illegal flag
//   vxsat_set_i             : sticky saturation event from lanes
//   vstart_wr_i/vstart_i    : trap load of vstart; vstart_clr_i clears it
//   vl_o .. vxrm_o          : current architectural state to the lanes
//   vs_dirty_o              : registered pulse after any vector state change
module vector_config_unit
    import vector_config_unit_pkg::*;
#(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [1:0]                cfg_op_i,
    input  logic [31:0]               cfg_avl_i,
    input  logic [31:0]               cfg_vtype_i,
    input  logic [4:0]                cfg_uimm_i,
    input  logic                      cfg_rs1_zero_i,
    input  logic                      cfg_rd_zero_i,
    output logic                      cfg_done_o,
    output logic [31:0]               cfg_vl_o,
    input  logic                      vec_busy_i,
    input  logic [1:0]                csr_op_i,
    input  logic [11:0]               csr_addr_i,
    input  logic [31:0]               csr_wdata_i,
    output logic [31:0]               csr_rdata_o,
    output logic                      csr_illegal_o,
    input  logic                      vxsat_set_i,
    input  logic                      vstart_wr_i,
    input  logic [$clog2(VLEN)-1:0]   vstart_i,
    input  logic                      vstart_clr_i,
    output logic [$clog2(VLEN):0]     vl_o,
    output logic [$clog2(VLEN):0]     vlmax_o,
    output logic [31:0]               vtype_o,
    output logic [2:0]                vsew_o,
    output logic [2:0]                vlmul_o,
    output logic                      vill_o,
    output logic [$clog2(VLEN)-1:0]   vstart_o,
    output logic [1:0]                vxrm_o,
    output logic                      vs_dirty_o
);

    localparam int unsigned VW  = $clog2(VLEN) + 1;
    localparam int unsigned VSW = $clog2(VLEN);
    localparam logic [31:0] VLENB = 32'(VLEN / 8);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_e;

    cfg_state_e state_q, state_d;
    logic       accept;
    logic       commit;

    // Latched request
    vcfg_op_e    req_op_q;
    logic [31:0] req_avl_q;
    logic [31:0] req_vtype_q;
    logic [4:0]  req_uimm_q;
    logic        req_rs1_zero_q;
    logic        req_rd_zero_q;

    // Architectural state
    logic [VW-1:0]  vl_q;
    logic [31:0]    vtype_q;
    logic [VSW-1:0] vstart_q, vstart_d;
    logic [1:0]     vxrm_q, vxrm_d;
    logic           vxsat_q, vxsat_d;
    logic           vs_dirty_q, vs_dirty_d;

    logic          req_illegal;
    logic [VW-1:0] req_vlmax;
    logic [31:0]   req_vtype_eff;
    logic          cur_illegal;
    logic [VW-1:0] cur_vlmax;
    logic [31:0]   cur_vtype_eff;

    logic [31:0]   avl;
    logic [VW-1:0] new_vl;

    csr_op_e        csr_op;
    logic           csr_known;
    logic           csr_ro;
    logic           csr_wr;
    logic [VSW-1:0] csr_wval;

    vector_config_unit_vtype_decode #(.VLEN(VLEN), .ELEN(ELEN)) u_req_decode (
        .vtype     (req_vtype_q),
        .illegal   (req_illegal),
        .vlmax     (req_vlmax),
        .vtype_eff (req_vtype_eff)
    );

    vector_config_unit_vtype_decode #(.VLEN(VLEN), .ELEN(ELEN)) u_cur_decode (
        .vtype     (vtype_q),
        .illegal   (cur_illegal),
        .vlmax     (cur_vlmax),
        .vtype_eff (cur_vtype_eff)
    );

    // ---------------- Configuration FSM ----------------
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) state_d = vec_busy_i ? ST_DRAIN : ST_COMMIT;
            end
            ST_DRAIN: begin
                if (!vec_busy_i) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = cfg_valid_i && cfg_ready_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // AVL selection and new vl from the latched operands
    always_comb begin
        if (req_op_q == VSETIVLI)                  avl = {27'd0, req_uimm_q};
        else if (req_rs1_zero_q && !req_rd_zero_q) avl = 32'(req_vlmax);
        else if (req_rs1_zero_q)                   avl = 32'(vl_q);
        else                                       avl = req_avl_q;
        // Full 32-bit compare so large AVLs saturate instead of wrapping.
        new_vl = (avl < 32'(req_vlmax)) ? VW'(avl) : req_vlmax;
    end

    assign cfg_done_o = commit;
    assign cfg_vl_o   = 32'(new_vl);

    // ---------------- CSR access ----------------
    always_comb begin
        csr_op      = csr_op_e'(csr_op_i);
        csr_rdata_o = '0;
        csr_known   = 1'b1;
        csr_ro      = 1'b0;
        case (csr_addr_i)
            CSR_VSTART: csr_rdata_o = 32'(vstart_q);
            CSR_VXSAT:  csr_rdata_o = 32'(vxsat_q);
            CSR_VXRM:   csr_rdata_o = 32'(vxrm_q);
            CSR_VCSR:   csr_rdata_o = 32'({vxrm_q, vxsat_q});
            CSR_VL:     begin csr_ro = 1'b1; csr_rdata_o = 32'(vl_q); end
            CSR_VTYPE:  begin csr_ro = 1'b1; csr_rdata_o = vtype_q; end
            CSR_VLENB:  begin csr_ro = 1'b1; csr_rdata_o = VLENB; end
            default:    csr_known = 1'b0;
        endcase

        csr_illegal_o = (csr_op != CSR_NONE)
                     && (!csr_known
                         || (csr_ro && ((csr_op == CSR_WRITE) || (csr_wdata_i != '0))));
        csr_wr = (csr_op != CSR_NONE) && !csr_illegal_o && !csr_ro;

        // Only the low VSW bits can reach any writable field.
        case (csr_op)
            CSR_WRITE: csr_wval = csr_wdata_i[VSW-1:0];
            CSR_SET:   csr_wval = csr_rdata_o[VSW-1:0] | csr_wdata_i[VSW-1:0];
            CSR_CLEAR: csr_wval = csr_rdata_o[VSW-1:0] & ~csr_wdata_i[VSW-1:0];
            default:   csr_wval = csr_rdata_o[VSW-1:0];
        endcase
    end

    always_comb begin
        vstart_d = vstart_q;
        if (csr_wr && (csr_addr_i == CSR_VSTART)) vstart_d = csr_wval;
        else if (vstart_wr_i)                     vstart_d = vstart_i;
        else if (vstart_clr_i)                    vstart_d = '0;

        vxsat_d = vxsat_q;
        if (csr_wr && ((csr_addr_i == CSR_VXSAT) || (csr_addr_i == CSR_VCSR))) vxsat_d = csr_wval[0];
        else if (vxsat_set_i)                                                 vxsat_d = 1'b1;

        vxrm_d = vxrm_q;
        if (csr_wr && (csr_addr_i == CSR_VXRM))      vxrm_d = csr_wval[1:0];
        else if (csr_wr && (csr_addr_i == CSR_VCSR)) vxrm_d = csr_wval[2:1];

        // Comparing next vs current covers CSR writes with no net effect.
        vs_dirty_d = commit
                  || (vstart_d != vstart_q)
                  || (vxsat_d != vxsat_q)
                  || (vxrm_d != vxrm_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_op_q       <= VSETVLI;
            req_avl_q      <= '0;
            req_vtype_q    <= '0;
            req_uimm_q     <= '0;
            req_rs1_zero_q <= 1'b0;
            req_rd_zero_q  <= 1'b0;
            vl_q           <= '0;
            vtype_q        <= VTYPE_VILL;
            vstart_q       <= '0;
            vxrm_q         <= '0;
            vxsat_q        <= 1'b0;
            vs_dirty_q     <= 1'b0;
        end else begin
            if (accept) begin
                req_op_q       <= vcfg_op_e'(cfg_op_i);
                req_avl_q      <= cfg_avl_i;
                req_vtype_q    <= cfg_vtype_i;
                req_uimm_q     <= cfg_uimm_i;
                req_rs1_zero_q <= cfg_rs1_zero_i;
                req_rd_zero_q  <= cfg_rd_zero_i;
            end
            if (commit) begin
                vl_q    <= new_vl;
                vtype_q <= req_vtype_eff;
            end
            vstart_q   <= vstart_d;
            vxrm_q     <= vxrm_d;
            vxsat_q    <= vxsat_d;
            vs_dirty_q <= vs_dirty_d;
        end
    end

    assign vl_o       = vl_q;
    assign vlmax_o    = cur_vlmax;
    assign vtype_o    = cur_vtype_eff;
    assign vsew_o     = cur_vtype_eff[5:3];
    assign vlmul_o    = cur_vtype_eff[2:0];
    assign vill_o     = cur_illegal;
    assign vstart_o   = vstart_q;
    assign vxrm_o     = vxrm_q;
    assign vs_dirty_o = vs_dirty_q;

endmodule

// File: tb/tb_vector_config_unit.sv
module tb_vector_config_unit;

    localparam int unsigned VLEN = 128;
    localparam int unsigned ELEN = 32;
    localparam int unsigned VW   = $clog2(VLEN) + 1;
    localparam int unsigned SW   = $clog2(VLEN);
    localparam int unsigned VILL = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid, cfg_ready_o;
    logic [1:0]    cfg_op;
    logic [31:0]   cfg_avl, cfg_vtype;
    logic [4:0]    cfg_uimm;
    logic          cfg_rs1_zero, cfg_rd_zero;
    logic          cfg_done_o;
    logic [31:0]   cfg_vl_o;
    logic          vec_busy;
    logic [1:0]    csr_op;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata, csr_rdata_o;
    logic          csr_illegal_o;
    logic          vxsat_set, vstart_wr, vstart_clr;
    logic [SW-1:0] vstart_idx;
    logic [VW-1:0] vl_o, vlmax_o;
    logic [31:0]   vtype_o;
    logic [2:0]    vsew_o, vlmul_o;
    logic          vill_o;
    logic [SW-1:0] vstart_o;
    logic [1:0]    vxrm_o;
    logic          vs_dirty_o;

    vector_config_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready_o), .cfg_op_i(cfg_op),
        .cfg_avl_i(cfg_avl), .cfg_vtype_i(cfg_vtype), .cfg_uimm_i(cfg_uimm),
        .cfg_rs1_zero_i(cfg_rs1_zero), .cfg_rd_zero_i(cfg_rd_zero),
        .cfg_done_o(cfg_done_o), .cfg_vl_o(cfg_vl_o), .vec_busy_i(vec_busy),
        .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .vxsat_set_i(vxsat_set), .vstart_wr_i(vstart_wr), .vstart_i(vstart_idx),
        .vstart_clr_i(vstart_clr), .vl_o(vl_o), .vlmax_o(vlmax_o), .vtype_o(vtype_o),
        .vsew_o(vsew_o), .vlmul_o(vlmul_o), .vill_o(vill_o), .vstart_o(vstart_o),
        .vxrm_o(vxrm_o), .vs_dirty_o(vs_dirty_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    int unsigned m_vl, m_vtype, m_vstart, m_vxrm, m_vxsat;

    typedef struct {
        int unsigned op, avl, vt, uimm;
        bit          z1, zd;
        int unsigned busy, ev, et, em;
    } cfg_vec_t;

    cfg_vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Configuration result from the architectural rules: LMUL as a ratio,
    // VLMAX = VLEN * LMUL / SEW.
    function automatic void ref_cfg(input int unsigned vt, input int unsigned op,
                                    input int unsigned avl, input int unsigned uimm,
                                    input bit z1, input bit zd, input int unsigned cur_vl,
                                    output int unsigned vl, output int unsigned vto,
                                    output int unsigned vlmax);
        int unsigned sew_code, num, den, sew, a;
        bit ill;
        sew_code = (vt >> 3) & 7;
        ill = ((vt >> 8) != 0);
        num = 1; den = 1;
        case (vt & 7)
            0: begin num = 1; den = 1; end
            1: begin num = 2; den = 1; end
            2: begin num = 4; den = 1; end
            3: begin num = 8; den = 1; end
            5: begin num = 1; den = 8; end
            6: begin num = 1; den = 4; end
            7: begin num = 1; den = 2; end
            default: ill = 1;
        endcase
        sew = 8 * (1 << sew_code);
        if (sew_code > 3 || sew * den > ELEN) ill = 1;
        vlmax = ill ? 0 : (VLEN * num) / (sew * den);
        if (op == 1)        a = uimm;
        else if (z1 && !zd) a = vlmax;
        else if (z1)        a = cur_vl;
        else                a = avl;
        vl    = ill ? 0 : ((a < vlmax) ? a : vlmax);
        vto   = ill ? VILL : vt;
    endfunction

    task automatic do_cfg(input int unsigned op, input int unsigned avl, input int unsigned vt,
                          input int unsigned uimm, input bit z1, input bit zd,
                          input int unsigned busy, input int unsigned ev,
                          input int unsigned et, input int unsigned em);
        cfg_op = op[1:0]; cfg_avl = avl; cfg_vtype = vt; cfg_uimm = uimm[4:0];
        cfg_rs1_zero = z1; cfg_rd_zero = zd;
        cfg_valid = 1'b1;
        vec_busy = (busy != 0);
        #1;
        check("ready_idle", 32'(cfg_ready_o), 1);
        tick;
        cfg_valid = 1'b0;
        if (busy != 0) begin
            for (int unsigned i = 1; i < busy; i++) begin
                check("drain_ready", 32'(cfg_ready_o), 0);
                check("drain_done", 32'(cfg_done_o), 0);
                check("drain_vl", 32'(vl_o), m_vl);
                tick;
            end
            check("drain_done_last", 32'(cfg_done_o), 0);
            check("drain_ready_last", 32'(cfg_ready_o), 0);
            vec_busy = 1'b0;
            tick;
        end
        check("done_pulse", 32'(cfg_done_o), 1);
        check("cfg_vl", cfg_vl_o, ev);
        check("vl_before_commit", 32'(vl_o), m_vl);
        tick;
        check("done_single", 32'(cfg_done_o), 0);
        check("ready_after", 32'(cfg_ready_o), 1);
        check("vl", 32'(vl_o), ev);
        check("vtype", vtype_o, et);
        check("vlmax", 32'(vlmax_o), em);
        check("vill", 32'(vill_o), et >> 31);
        check("vsew", 32'(vsew_o), (et >> 3) & 7);
        check("vlmul", 32'(vlmul_o), et & 7);
        check("dirty_commit", 32'(vs_dirty_o), 1);
        m_vl = ev;
        m_vtype = et;
    endtask

    function automatic int unsigned m_read(input int unsigned addr);
        case (addr)
            'h008: return m_vstart;
            'h009: return m_vxsat;
            'h00A: return m_vxrm;
            'h00F: return m_vxrm * 2 + m_vxsat;
            'hC20: return m_vl;
            'hC21: return m_vtype;
            'hC22: return VLEN / 8;
            default: return 0;
        endcase
    endfunction

    task automatic csr_access(input int unsigned op, input int unsigned addr,
                              input int unsigned wdata, input bit sat, input bit swr,
                              input int unsigned sidx, input bit sclr);
        int unsigned old, nv, p_vstart, p_vxrm, p_vxsat;
        bit known, ro, ill, hit_sat, hit_vs, changed;
        csr_op = op[1:0]; csr_addr = addr[11:0]; csr_wdata = wdata;
        vxsat_set = sat; vstart_wr = swr; vstart_idx = sidx[SW-1:0]; vstart_clr = sclr;
        #1;
        known = (addr == 'h008 || addr == 'h009 || addr == 'h00A || addr == 'h00F ||
                 addr == 'hC20 || addr == 'hC21 || addr == 'hC22);
        ro  = (addr >= 'hC20 && addr <= 'hC22);
        ill = (op != 0) && (!known || (ro && (op == 1 || wdata != 0)));
        old = m_read(addr);
        check("csr_illegal", 32'(csr_illegal_o), 32'(ill));
        check("csr_rdata", csr_rdata_o, old);
        p_vstart = m_vstart; p_vxrm = m_vxrm; p_vxsat = m_vxsat;
        nv = (op == 1) ? wdata : (op == 2) ? (old | wdata) : (old & ~wdata);
        hit_sat = 0; hit_vs = 0;
        if (op != 0 && !ill && !ro) begin
            case (addr)
                'h008: begin m_vstart = nv % VLEN; hit_vs = 1; end
                'h009: begin m_vxsat = nv & 1; hit_sat = 1; end
                'h00A: m_vxrm = nv & 3;
                'h00F: begin m_vxrm = (nv >> 1) & 3; m_vxsat = nv & 1; hit_sat = 1; end
                default: ;
            endcase
        end
        if (!hit_sat && sat) m_vxsat = 1;
        if (!hit_vs) begin
            if (swr)       m_vstart = sidx;
            else if (sclr) m_vstart = 0;
        end
        changed = (p_vstart != m_vstart) || (p_vxrm != m_vxrm) || (p_vxsat != m_vxsat);
        tick;
        csr_op = 2'd0; csr_wdata = '0; vxsat_set = 0; vstart_wr = 0; vstart_clr = 0;
        check("vstart", 32'(vstart_o), m_vstart);
        check("vxrm", 32'(vxrm_o), m_vxrm);
        check("dirty_csr", 32'(vs_dirty_o), 32'(changed));
        csr_addr = 12'h009;
        #1;
        check("vxsat_read", csr_rdata_o, m_vxsat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ev, et, em;
        reset = 1'b1;
        cfg_valid = 0; cfg_op = 0; cfg_avl = 0; cfg_vtype = 0; cfg_uimm = 0;
        cfg_rs1_zero = 0; cfg_rd_zero = 0; vec_busy = 0;
        csr_op = 0; csr_addr = 12'h009; csr_wdata = 0;
        vxsat_set = 0; vstart_wr = 0; vstart_idx = 0; vstart_clr = 0;
        m_vl = 0; m_vtype = VILL; m_vstart = 0; m_vxrm = 0; m_vxsat = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(cfg_ready_o), 1);
        check("rst_done", 32'(cfg_done_o), 0);
        check("rst_vill", 32'(vill_o), 1);
        check("rst_vtype", vtype_o, VILL);
        check("rst_vl", 32'(vl_o), 0);
        check("rst_vlmax", 32'(vlmax_o), 0);
        check("rst_vsew", 32'(vsew_o), 0);
        check("rst_vlmul", 32'(vlmul_o), 0);
        check("rst_vstart", 32'(vstart_o), 0);
        check("rst_vxrm", 32'(vxrm_o), 0);
        check("rst_vxsat", csr_rdata_o, 0);
        check("rst_dirty", 32'(vs_dirty_o), 0);
        reset = 1'b0;
        tick;

        // op, avl, vtype, uimm, rs1z, rdz, busy, exp vl, exp vtype, exp vlmax
        tbl.push_back('{0, 100,          'h011, 0,  0, 0, 0, 8,   'h011, 8});
        tbl.push_back('{0, 100,          'h018, 0,  0, 0, 0, 0,   VILL,  0});
        tbl.push_back('{0, 5,            'h00E, 0,  0, 0, 0, 0,   VILL,  0});
        tbl.push_back('{1, 0,            'h006, 3,  0, 0, 0, 3,   'h006, 4});
        tbl.push_back('{0, 100,          'h011, 0,  0, 0, 5, 8,   'h011, 8});
        tbl.push_back('{0, 0,            'h010, 0,  1, 1, 0, 4,   'h010, 4});
        tbl.push_back('{0, 0,            'h0C3, 0,  1, 0, 2, 128, 'h0C3, 128});
        tbl.push_back('{2, 5,            'h100, 0,  0, 0, 0, 0,   VILL,  0});
        tbl.push_back('{2, 7,            'h007, 0,  0, 0, 1, 7,   'h007, 8});
        tbl.push_back('{0, 9,            'h015, 0,  0, 0, 0, 0,   VILL,  0});
        tbl.push_back('{0, 9,            'h004, 0,  0, 0, 0, 0,   VILL,  0});
        tbl.push_back('{0, 0,            'h010, 0,  1, 1, 0, 0,   'h010, 4});
        tbl.push_back('{1, 50,           'h00B, 31, 0, 0, 0, 31,  'h00B, 64});
        tbl.push_back('{0, 'h102,        'h000, 0,  0, 0, 0, 16,  'h000, 16});
        tbl.push_back('{0, 'hFFFF_FFFF,  'h020, 0,  0, 0, 0, 0,   VILL,  0});
        foreach (tbl[i])
            do_cfg(tbl[i].op, tbl[i].avl, tbl[i].vt, tbl[i].uimm, tbl[i].z1, tbl[i].zd,
                   tbl[i].busy, tbl[i].ev, tbl[i].et, tbl[i].em);

        // Reset in the middle of a drain aborts the request.
        do_cfg(0, 100, 'h011, 0, 0, 0, 0, 8, 'h011, 8);
        cfg_op = 0; cfg_avl = 3; cfg_vtype = 'h010; cfg_rs1_zero = 0; cfg_rd_zero = 0;
        cfg_valid = 1; vec_busy = 1;
        tick;
        cfg_valid = 0;
        check("drain_before_reset", 32'(cfg_ready_o), 0);
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(cfg_ready_o), 1);
        check("abort_vill", 32'(vill_o), 1);
        check("abort_vl", 32'(vl_o), 0);
        check("abort_vtype", vtype_o, VILL);
        tick;
        reset = 1'b0;
        vec_busy = 0;
        m_vl = 0; m_vtype = VILL; m_vstart = 0; m_vxrm = 0; m_vxsat = 0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(cfg_done_o), 0);
            tick;
        end

        // CSR corner sequences
        csr_access(1, 'h00F, 'h5, 0, 0, 0, 0);
        check("vcsr_vxrm", 32'(vxrm_o), 2);
        check("vcsr_vxsat", csr_rdata_o, 1);
        do_cfg(0, 100, 'h011, 0, 0, 0, 0, 8, 'h011, 8);
        csr_access(2, 'hC20, 1, 0, 0, 0, 0);
        check("set_vl_illegal_vl", 32'(vl_o), 8);
        csr_access(3, 'h009, 1, 1, 0, 0, 0);
        check("clear_beats_set", csr_rdata_o, 0);
        csr_access(0, 'h008, 0, 0, 1, 7, 1);
        check("vstart_wr_wins", 32'(vstart_o), 7);
        check("vstart_wr_dirty", 32'(vs_dirty_o), 1);
        csr_access(0, 'h008, 0, 0, 0, 0, 1);
        check("vstart_clr", 32'(vstart_o), 0);
        check("vstart_clr_dirty", 32'(vs_dirty_o), 1);
        csr_access(0, 'h008, 0, 0, 0, 0, 0);
        check("no_change_dirty", 32'(vs_dirty_o), 0);
        csr_access(2, 'hC22, 0, 0, 0, 0, 0);
        csr_access(1, 'h123, 5, 0, 0, 0, 0);

        // Randomized configuration requests against the reference model
        for (int i = 0; i < 40; i++) begin
            int unsigned vt, avl, uimm, op, busy;
            bit z1, zd;
            vt = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) vt = vt | (32'h1 << $urandom_range(8, 31));
            op = $urandom_range(0, 2);
            avl = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 140);
            uimm = $urandom_range(0, 31);
            z1 = ($urandom_range(0, 3) == 0);
            zd = ($urandom_range(0, 1) == 1);
            busy = $urandom_range(0, 3);
            ref_cfg(vt, op, avl, uimm, z1, zd, m_vl, ev, et, em);
            do_cfg(op, avl, vt, uimm, z1, zd, busy, ev, et, em);
        end

        // Randomized CSR traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            int unsigned addr, sel, wdata;
            sel = $urandom_range(0, 7);
            case (sel)
                0: addr = 'h008; 1: addr = 'h009; 2: addr = 'h00A; 3: addr = 'h00F;
                4: addr = 'hC20; 5: addr = 'hC21; 6: addr = 'hC22;
                default: addr = 'h100 + $urandom_range(0, 255);
            endcase
            wdata = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
            csr_access($urandom_range(0, 3), addr, wdata,
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                       $urandom_range(0, VLEN - 1), ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
